mem_io_responder: RTL and testbench
===================================

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 Parameter RAM_AW, default 17: RAM byte-address width (128 KB).
REQ-002 Parameter TX_DEPTH, default 8: TX FIFO entries, a power of two, at least 4.
REQ-003 Port clk_in, input, 1: the single clock; all state changes on the rising edge.
REQ-004 Port rst_in, input, 1: reset, synchronous and active-low.
REQ-005 Port mem_a, input, 32: byte address from the CPU.
REQ-006 Port mem_dout, input, 8: write data from the CPU.
REQ-007 Port mem_wr, input, 1: 1 = write, 0 = read; a request is presented every cycle.
REQ-008 Port mem_din, output, 8: read data to the CPU, registered.
REQ-009 Port io_buffer_full, output, 1: TX FIFO almost full.
REQ-010 Port tx_data, output, 8: head byte of the TX FIFO.
REQ-011 Port tx_valid, output, 1: TX FIFO non-empty.
REQ-012 Port tx_ready, input, 1: UART transmitter accepts tx_data.
REQ-013 Port rx_data, input, 8: byte from the UART receiver.
REQ-014 Port rx_valid, input, 1: rx_data valid.
REQ-015 Port rx_ready, output, 1: RX holding register empty.
REQ-016 Port program_stop, output, 1: sticky end-of-program flag.

Function
REQ-017 Decode: mem_a[17:16]==2'b11 SHALL select I/O; otherwise RAM byte index is mem_a[RAM_AW-1:0].
REQ-018 RAM read SHALL return mem_din = RAM[index] exactly one cycle after the request; mem_din holds its value on write cycles.
REQ-019 RAM write SHALL update RAM[index] at the request edge; a read of that address in the next cycle SHALL return the new byte.
REQ-020 Read of 0x30000 with the RX register full SHALL return the held byte next cycle and empty the register; when the register is empty the read SHALL return 0x00.
REQ-021 rx_ready SHALL equal NOT rx_full; the RX register SHALL load on rx_valid && rx_ready.
REQ-022 A 0x30000 read and an RX load in the same cycle SHALL both take effect: the read returns 0x00 and the register becomes full.
REQ-023 Cycle counter: 32-bit, 0 at reset, increments every cycle, wraps 0xFFFFFFFF -> 0.
REQ-024 Read of 0x30004 SHALL snapshot the counter; reads of 0x30004..0x30007 SHALL return snapshot bytes 0..3 (little-endian) next cycle.
REQ-025 Write of 0x30000 with a nonzero byte SHALL enqueue mem_dout into the TX FIFO; a 0x00 byte SHALL be ignored.
REQ-026 Write of 0x30004 SHALL enqueue 0x00 (bypassing the zero filter) and set program_stop to 1 the following cycle; program_stop stays 1 until reset.
REQ-027 The TX FIFO SHALL dequeue on tx_valid && tx_ready; tx_data is the head, valid the same cycle tx_valid is 1.
REQ-028 Simultaneous enqueue and dequeue SHALL leave the count unchanged.
REQ-029 An enqueue when the count equals TX_DEPTH SHALL drop the byte, with no other effect.
REQ-030 io_buffer_full SHALL be registered and SHALL be 1 iff count >= TX_DEPTH-1 after the current edge.
REQ-031 All other I/O addresses SHALL read 0x00, and writes to them SHALL be ignored.

Reset
REQ-032 While rst_in==0 at an edge, the block SHALL set mem_din=0x00, tx_valid=0, io_buffer_full=0, program_stop=0, TX count=0, RX empty (rx_ready=1), counter=0 and snapshot=0.
REQ-033 RAM contents SHALL NOT be cleared by reset.
REQ-034 A request in progress during reset SHALL be discarded: no RAM write, no enqueue, no RX consume.
REQ-035 Normal operation SHALL resume on the first edge with rst_in==1.

Verification
REQ-036 Write 0xA5 to 0x00123, then read 0x00123 next cycle -> mem_din=0xA5 one cycle after the read.
REQ-037 tx_ready=0; write 0x41 x7 to 0x30000 -> io_buffer_full=1 after the 7th, count 7; 9th and 10th writes -> 8 then dropped; tx_ready=1 -> 0x41 drained, tx_valid falls after 8 bytes.
REQ-038 Write 0x00 to 0x30000 -> tx_valid stays 0; write any byte to 0x30004 -> TX FIFO holds 0x00, program_stop=1 next cycle and stays 1.
REQ-039 Drive rx_data=0x37, rx_valid=1 for 1 cycle -> rx_ready=0; read 0x30000 -> mem_din=0x37, rx_ready=1; second read -> 0x00.
REQ-040 Counter at 0x000000FF, read 0x30004 then 0x30005..0x30007 -> bytes 0xFF,0x00,0x00,0x00 (snapshot held despite counting).
REQ-041 Assert rst_in=0 mid-write to 0x30000 with 3 bytes queued -> tx_valid=0, io_buffer_full=0, no byte enqueued, RAM data preserved.

Source files
------------

// File: rtl/mem_io_responder.sv
// CPU-facing byte memory responder: RAM plus an I/O page at 0x30000 holding the
// UART TX FIFO, RX holding register, cycle counter snapshot and end-of-program flag.
module mem_io_responder #(
    parameter int RAM_AW   = 17,
    parameter int TX_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        program_stop
);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(TX_DEPTH);
    localparam logic [CW-1:0] ALMOST_C = CW'(TX_DEPTH - 1);

    logic [7:0] ram_q [0:(1<<RAM_AW)-1];
    logic [7:0] fifo_q [0:TX_DEPTH-1];

    logic [7:0]    din_q, din_d;
    logic          rx_full_q, rx_full_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic [31:0]   cyc_q;
    logic [31:0]   snap_q, snap_d;
    logic          stop_q, stop_d;
    logic          full_q;
    logic [PW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q, cnt_d;

    logic              io_sel, io_data, io_cnt, io_snap;
    logic [RAM_AW-1:0] ram_idx;
    logic              enq, enq_ok, deq;
    logic [7:0]        enq_byte;
    logic              unused_addr;

    assign io_sel      = (mem_a[17:16] == 2'b11);
    assign io_data     = io_sel && (mem_a[15:0] == 16'h0000);
    assign io_cnt      = io_sel && (mem_a[15:0] == 16'h0004);
    assign io_snap     = io_sel && (mem_a[15:2] == 14'h0001) && (mem_a[1:0] != 2'b00);
    assign ram_idx     = mem_a[RAM_AW-1:0];
    assign unused_addr = ^mem_a[31:18];

    assign tx_valid = (cnt_q != '0);
    assign deq      = tx_valid && tx_ready;
    assign enq_ok   = enq && (cnt_q != DEPTH_C);

    always_comb begin
        din_d     = din_q;
        rx_full_d = rx_full_q;
        rx_byte_d = rx_byte_q;
        snap_d    = snap_q;
        stop_d    = stop_q;
        enq       = 1'b0;
        enq_byte  = mem_dout;
        if (!mem_wr) begin
            if (!io_sel) begin
                din_d = ram_q[ram_idx];
            end else if (io_data) begin
                din_d     = rx_full_q ? rx_byte_q : 8'h00;
                rx_full_d = 1'b0;
            end else if (io_cnt) begin
                // byte 0 comes straight from the counter so it matches the new snapshot
                din_d  = cyc_q[7:0];
                snap_d = cyc_q;
            end else if (io_snap) begin
                case (mem_a[1:0])
                    2'd1:    din_d = snap_q[15:8];
                    2'd2:    din_d = snap_q[23:16];
                    default: din_d = snap_q[31:24];
                endcase
            end else begin
                din_d = 8'h00;
            end
        end else if (io_data) begin
            enq = (mem_dout != 8'h00);
        end else if (io_cnt) begin
            enq      = 1'b1;
            enq_byte = 8'h00;
            stop_d   = 1'b1;
        end
        // a load can only happen while empty, so it never clobbers an unread byte
        if (rx_valid && !rx_full_q) begin
            rx_full_d = 1'b1;
            rx_byte_d = rx_data;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({enq_ok, deq})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            din_q     <= 8'h00;
            rx_full_q <= 1'b0;
            rx_byte_q <= 8'h00;
            cyc_q     <= 32'h0;
            snap_q    <= 32'h0;
            stop_q    <= 1'b0;
            full_q    <= 1'b0;
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
        end else begin
            din_q     <= din_d;
            rx_full_q <= rx_full_d;
            rx_byte_q <= rx_byte_d;
            cyc_q     <= cyc_q + 32'd1;
            snap_q    <= snap_d;
            stop_q    <= stop_d;
            full_q    <= (cnt_d >= ALMOST_C);
            cnt_q     <= cnt_d;
            if (enq_ok) wp_q <= wp_q + PW'(1);
            if (deq)    rp_q <= rp_q + PW'(1);
        end
    end

    // storage arrays carry no reset; writes are simply suppressed while in reset
    always_ff @(posedge clk_in) begin
        if (rst_in && mem_wr && !io_sel) ram_q[ram_idx] <= mem_dout;
        if (rst_in && enq_ok)            fifo_q[wp_q]   <= enq_byte;
    end

    assign mem_din        = din_q;
    assign io_buffer_full = full_q;
    assign tx_data        = fifo_q[rp_q];
    assign rx_ready       = !rx_full_q;
    assign program_stop   = stop_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed plus randomized bench for mem_io_responder, checked against a
// transaction-level model built from a byte map, a queue and plain counters.
module tb_mem_io_responder;
    localparam int RAM_AW   = 17;
    localparam int TX_DEPTH = 8;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [31:0] mem_a = 32'h0;
    logic [7:0]  mem_dout = 8'h0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        program_stop;

    mem_io_responder #(.RAM_AW(RAM_AW), .TX_DEPTH(TX_DEPTH)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_dout(mem_dout),
        .mem_wr(mem_wr), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .program_stop(program_stop)
    );

    always #5 clk_in = ~clk_in;

    // reference model state
    logic [7:0]  ram_m [int];
    logic [7:0]  fifo_m [$];
    logic [7:0]  m_din;
    logic        m_known;
    logic        m_rx_full;
    logic [7:0]  m_rx;
    logic [31:0] m_cnt;
    logic [31:0] m_snap;
    logic        m_stop;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic [31:0] a, input logic wr, input logic [7:0] d,
                        input logic txr, input logic rxv, input logic [7:0] rxd,
                        input logic rst);
        logic io, enq, rxload;
        logic [7:0] eb;
        int idx, pre;
        mem_a = a; mem_wr = wr; mem_dout = d;
        tx_ready = txr; rx_valid = rxv; rx_data = rxd; rst_in = rst;
        pre = fifo_m.size();
        @(posedge clk_in);
        if (!rst) begin
            m_din = 8'h00; m_known = 1'b1; fifo_m.delete();
            m_rx_full = 1'b0; m_cnt = 32'h0; m_snap = 32'h0; m_stop = 1'b0;
        end else begin
            io     = (a[17:16] == 2'b11);
            idx    = int'(a[RAM_AW-1:0]);
            rxload = rxv && !m_rx_full;
            enq    = 1'b0;
            eb     = d;
            if (!wr) begin
                if (!io) begin
                    if (ram_m.exists(idx)) begin m_din = ram_m[idx]; m_known = 1'b1; end
                    else m_known = 1'b0;
                end else if (a[15:0] == 16'h0) begin
                    m_din = m_rx_full ? m_rx : 8'h00;
                    m_rx_full = 1'b0;
                end else if (a[15:0] == 16'h4) begin
                    m_snap = m_cnt;
                    m_din  = m_cnt[7:0];
                end else if (a[15:0] >= 16'h5 && a[15:0] <= 16'h7) begin
                    m_din = 8'((m_snap >> (8 * int'(a[1:0]))) & 32'hFF);
                end else begin
                    m_din = 8'h00;
                end
                if (io) m_known = 1'b1;
            end else begin
                if (!io) ram_m[idx] = d;
                else if (a[15:0] == 16'h0) enq = (d != 8'h00);
                else if (a[15:0] == 16'h4) begin enq = 1'b1; eb = 8'h00; m_stop = 1'b1; end
            end
            if (rxload) begin m_rx_full = 1'b1; m_rx = rxd; end
            if (txr && pre > 0) void'(fifo_m.pop_front());
            if (enq && pre < TX_DEPTH) fifo_m.push_back(eb);
            m_cnt = m_cnt + 32'd1;
        end
        #1;
        if (m_known) check("mem_din", 32'(mem_din), 32'(m_din));
        check("tx_valid", 32'(tx_valid), 32'(fifo_m.size() != 0));
        if (fifo_m.size() != 0) check("tx_data", 32'(tx_data), 32'(fifo_m[0]));
        check("io_buffer_full", 32'(io_buffer_full), 32'(fifo_m.size() >= TX_DEPTH - 1));
        check("rx_ready", 32'(rx_ready), 32'(!m_rx_full));
        check("program_stop", 32'(program_stop), 32'(m_stop));
    endtask

    task automatic idle(input logic txr);
        step(32'h0003_0010, 1'b0, 8'h00, txr, 1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        logic [31:0] a;
        int r;
        // reset and basic RAM write/read-back
        step(32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        step(32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        step(32'h0000_0123, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b1);
        step(32'h0000_0123, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        check("ram_readback_A5", 32'(mem_din), 32'hA5);
        // aliased upper address bits still hit RAM
        step(32'hFF00_0105, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b1);
        step(32'h0000_0105, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);

        // fill TX FIFO past capacity, then drain
        for (int i = 0; i < 10; i++) step(32'h0003_0000, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b1);
        check("fifo_len_after_overflow", 32'(fifo_m.size()), 32'(TX_DEPTH));
        for (int i = 0; i < 10; i++) idle(1'b1);

        // zero filter, then end-of-program marker
        step(32'h0003_0000, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        step(32'h0003_0004, 1'b1, 8'h99, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b0);
        idle(1'b1);

        // RX holding register
        step(32'h0003_0010, 1'b0, 8'h00, 1'b0, 1'b1, 8'h37, 1'b1);
        step(32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        check("rx_read_37", 32'(mem_din), 32'h37);
        step(32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        // read while loading: returns 0, register becomes full
        step(32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b1);
        step(32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'hEE, 1'b1);

        // counter snapshot at 0xFF
        for (int i = 0; i < 400 && m_cnt != 32'hFF; i++) idle(1'b0);
        check("counter_reached_ff", m_cnt, 32'hFF);
        for (int k = 4; k < 8; k++) step(32'h0003_0000 | 32'(k), 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        check("snap_byte3", 32'(mem_din), 32'h00);

        // reset in the middle of a TX write with 3 bytes queued, and a RAM write
        for (int i = 0; i < 3; i++) step(32'h0003_0000, 1'b1, 8'h61 + 8'(i), 1'b0, 1'b0, 8'h00, 1'b1);
        step(32'h0003_0000, 1'b1, 8'h64, 1'b0, 1'b1, 8'h11, 1'b0);
        step(32'h0000_0123, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0);
        step(32'h0000_0123, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        check("ram_kept_across_reset", 32'(mem_din), 32'hA5);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 3)      a = ($urandom & 32'hFFFC_0000) | (32'h100 + 32'($urandom_range(0, 15)));
            else if (r <= 5) a = 32'h0003_0000;
            else if (r <= 7) a = 32'h0003_0004 + 32'($urandom_range(0, 3));
            else if (r == 8) a = 32'h0003_0000;
            else             a = ($urandom_range(0, 1) != 0) ? 32'h0003_0010 : 32'h0003_1000;
            step(a, ($urandom_range(0, 1) != 0), 8'($urandom), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 60) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
